// File: rtl/gray_stream_checker.sv
// Gray-code stream checker: converts accepted Gray samples to binary and flags non-unit steps.
// Optional saturating error counter enabled by defining GRAY_CHK_ERR_COUNT_EN.
module gray_stream_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             first,
    output logic             step_err,
    output logic             dir_up,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {
        S_EMPTY,
        S_TRACK
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_prev_gray;
    logic [WIDTH-1:0] r_prev_bin;
    logic [WIDTH-1:0] r_bin;
    logic             r_out_valid;
    logic             r_first;
    logic             r_step_err;
    logic             r_dir_up;
    logic             r_err_sticky;

    logic             w_accept;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;
    logic             w_one_bit;
    logic             w_first;
    logic             w_step_err;
    logic             w_dir_up;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        logic acc;
        w_bin           = '0;
        acc             = gray_in[WIDTH-1];
        w_bin[WIDTH-1]  = acc;
        for (int unsigned k = 1; k < WIDTH; k++) begin
            acc                  = acc ^ gray_in[WIDTH-1-k];
            w_bin[WIDTH-1-k]     = acc;
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_diff    = gray_in ^ r_prev_gray;
    assign w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - WIDTH'(1))) == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_first     = (r_state == S_EMPTY) || sync_clr;
        w_step_err  = 1'b0;
        w_dir_up    = 1'b0;
        if (!w_first) begin
            w_step_err = !w_one_bit;
            w_dir_up   = w_one_bit && (w_bin == r_prev_bin + WIDTH'(1));
        end
        if (w_accept) begin
            w_state_nxt = S_TRACK;
        end else if (sync_clr) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_EMPTY;
            r_prev_gray  <= '0;
            r_prev_bin   <= '0;
            r_bin        <= '0;
            r_out_valid  <= 1'b0;
            r_first      <= 1'b0;
            r_step_err   <= 1'b0;
            r_dir_up     <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_prev_gray <= gray_in;
                r_prev_bin  <= w_bin;
                r_bin       <= w_bin;
                r_first     <= w_first;
                r_step_err  <= w_step_err;
                r_dir_up    <= w_dir_up;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (sync_clr) begin
                r_err_sticky <= 1'b0;
            end else if (w_accept && w_step_err) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

`ifdef GRAY_CHK_ERR_COUNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (sync_clr) begin
            r_err_count <= '0;
        end else if (w_accept && w_step_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign bin_out    = r_bin;
    assign out_valid  = r_out_valid;
    assign first      = r_first;
    assign step_err   = r_step_err;
    assign dir_up     = r_dir_up;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_gray_stream_checker.sv
// Scoreboard bench for gray_stream_checker: directed plan vectors followed by randomized traffic.
// The reference model works on whole words (shift-xor conversion, popcount, modular increment).
module tb_gray_stream_checker;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sync_clr = 1'b0;
    logic [W-1:0]  bin_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          first;
    logic          step_err;
    logic          dir_up;
    logic          err_sticky;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    gray_stream_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sync_clr   (sync_clr),
        .bin_out    (bin_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .first      (first),
        .step_err   (step_err),
        .dir_up     (dir_up),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    typedef struct {
        int bin;
        int first;
        int step_err;
        int dir_up;
        int sticky;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    bit   m_have   = 0;
    int   m_prev   = 0;
    int   m_sticky = 0;
    int   m_cnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b & ((1 << W) - 1);
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & ((1 << W) - 1);
    endfunction

    task automatic model_clear();
        m_have   = 0;
        m_sticky = 0;
        m_cnt    = 0;
    endtask

    task automatic model_accept(input int g, input bit clr);
        exp_t e;
        int   pb;
        if (clr) model_clear();
        pb         = g2b(m_prev);
        e.bin      = g2b(g);
        e.first    = m_have ? 0 : 1;
        e.step_err = (m_have && $countones(g ^ m_prev) != 1) ? 1 : 0;
        e.dir_up   = (m_have && !e.step_err && e.bin == ((pb + 1) % (1 << W))) ? 1 : 0;
        if (e.step_err != 0) begin
            m_sticky = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        e.sticky = m_sticky;
`ifdef GRAY_CHK_ERR_COUNT_EN
        e.cnt = m_cnt;
`else
        e.cnt = 0;
`endif
        q.push_back(e);
        m_have = 1;
        m_prev = g;
    endtask

    // One cycle of stimulus; acceptance is decided from the model's view of out_valid.
    task automatic step(input bit v, input int g, input bit ordy, input bit clr);
        bit exp_rdy;
        @(negedge clk);
        in_valid  = v;
        gray_in   = W'(g);
        out_ready = ordy;
        sync_clr  = clr;
        #1;
        check("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
        exp_rdy = (q.size() == 0) || ordy;
        check("in_ready", int'(in_ready), exp_rdy ? 1 : 0);
        if (v && exp_rdy) model_accept(g, clr);
        else if (clr) model_clear();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sync_clr  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_first", int'(first), 0);
        check("rst_step_err", int'(step_err), 0);
        check("rst_dir_up", int'(dir_up), 0);
        check("rst_err_sticky", int'(err_sticky), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        q.delete();
        model_clear();
    endtask

    // Monitor: consumes one expected result per output transfer.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", int'(out_valid), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bin_out", int'(bin_out), e.bin);
                check("first", int'(first), e.first);
                check("step_err", int'(step_err), e.step_err);
                check("dir_up", int'(dir_up), e.dir_up);
                check("err_sticky", int'(err_sticky), e.sticky);
                check("err_count", int'(err_count), e.cnt);
            end
        end
    end

    initial begin
        int held;
        int g;
        repeat (2) @(negedge clk);
        do_reset();

        // Counting up from zero.
        step(1, 4'b0000, 1, 0);
        step(1, 4'b0001, 1, 0);
        step(1, 4'b0011, 1, 0);
        step(1, 4'b0010, 1, 0);

        // Wrap-around both directions.
        step(1, 4'b1000, 1, 1);
        step(1, 4'b0000, 1, 0);
        step(1, 4'b1000, 1, 0);

        // Multi-bit step and repeated code.
        step(1, 4'b0001, 1, 1);
        step(1, 4'b0111, 1, 0);
        step(1, 4'b0111, 1, 0);
        step(0, 0, 1, 0);
        check("sticky_after_errors", int'(err_sticky), 1);

        // Backpressure: result held, input blocked.
        step(1, 4'b0101, 1, 0);
        held = int'(bin_out);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0100, 0, 0);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_bin_stable", int'(bin_out), 6);
        end
        step(1, 4'b0100, 1, 0);
        step(0, 0, 1, 0);

        // Clear with same-cycle accept after errors.
        step(1, 4'b0000, 1, 0);
        step(1, 4'b0011, 1, 1);
        step(0, 0, 1, 0);

        // Reset with a result pending.
        step(1, 4'b0001, 0, 0);
        do_reset();
        step(1, 4'b0001, 1, 0);

        // Saturation of the narrow counter.
        for (int i = 0; i < 4; i++) step(1, (i % 2 == 0) ? 4'b1110 : 4'b0001, 1, 0);
        step(0, 0, 1, 0);
`ifdef GRAY_CHK_ERR_COUNT_EN
        check("err_count_saturated", int'(err_count), 3);
`else
        check("err_count_tied", int'(err_count), 0);
`endif

        // Randomized traffic, mostly unit steps with occasional jumps.
        for (int i = 0; i < 2000; i++) begin
            bit v, ordy, clr;
            int r;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            r    = $urandom_range(0, 9);
            if (r < 4)      g = b2g((g2b(m_prev) + 1) % (1 << W));
            else if (r < 8) g = b2g((g2b(m_prev) + (1 << W) - 1) % (1 << W));
            else if (r < 9) g = m_prev;
            else            g = $urandom_range(0, (1 << W) - 1);
            clr = v && ordy && ($urandom_range(0, 39) == 0);
            step(v, g, ordy, clr);
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
